mux_nx1_stream: RTL and testbench
=================================

// Module: mux_nx1_stream
//
// PURPOSE
// - Parametrised N-channel, W-bit stream multiplexer with valid/ready handshake on every channel.
// - Registered single-stage output; supersedes plain combinational 4:1 bit muxes where data arrives as streams.
// - Two selection modes: external select (MODE=0) or round-robin arbitration (MODE=1).
// - Sits between N producer streams and one consumer, e.g. funnelling lab peripherals onto one display/UART path.
//
// PARAMETERS
// - CH    4  number of input channels, >= 2, power of 2 not required
// - W     8  data width per channel, >= 1
// - MODE  0  0 = channel chosen by select; 1 = round-robin, select ignored
// - SELW (localparam) = $clog2(CH), minimum 1
//
// PORTS
// - clk        in   1       rising-edge clock
// - reset      in   1       synchronous, active-high reset
// - in_data    in   CH*W    channel k occupies bits [k*W +: W]
// - in_valid   in   CH      channel k holds a word
// - in_ready   out  CH      channel k word accepted this cycle when in_valid[k] also high
// - select     in   SELW    channel choice, MODE=0 only
// - out_data   out  W       registered output word
// - out_valid  out  1       out_data holds an unconsumed word
// - out_ready  in   1       consumer accepts out_data this cycle
// - out_ch     out  SELW    source channel of out_data
//
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, out_ch=0, rr pointer=0, in_ready=all 0 while reset high.
// - load_en = !out_valid || out_ready (output register free or draining this cycle).
// - Grant g is computed combinationally; in_ready[g] = load_en && grant_ok; all other in_ready bits 0; at most one bit high.
// - Transfer when in_valid[g] && in_ready[g]: next edge out_data<=word g, out_ch<=g, out_valid<=1. Latency 1 clk.
// - load_en && no transfer: out_valid<=0 next edge. !load_en: out_* held unchanged.
// - Full throughput: one word per clk with out_ready held high; no bubbles.
// - MODE=0: g=select; grant_ok = (select < CH). select >= CH -> no in_ready, out_valid drops once drained.
// - MODE=1: g = first k with in_valid[k], scanning ptr, ptr+1, ..., CH-1, 0, ..., ptr-1; grant_ok = |in_valid.
//   - After a transfer from g: ptr <= (g == CH-1) ? 0 : g+1. No transfer: ptr unchanged.
// - Only channel g is accepted per cycle; other valids wait, no data dropped.
// - in_ready may depend combinationally on in_valid and out_ready; in_valid/out_valid never depend on ready.
// - Reset mid-stream: pending out word discarded; producers must re-present data after reset falls.
//
// CONFIGURATION
// - MUX_NX1_STREAM_PARITY_EN defined: extra port out_parity (out, 1) = XOR of out_data, registered with out_data,
//   0 after reset, held with out_data when stalled.
// - Undefined: out_parity port absent; all other behaviour identical.
//
// STRUCTURE
// - Shared package mux_pkg: MODE_SELECT=0, MODE_RR=1 constants; clog2-based SELW helper.
// - Sub-module rr_arbiter (CH parameter): in_valid vector + ptr -> one-hot grant + encoded index; used only when MODE=1.
// - Output register and handshake logic live in mux_nx1_stream.
//
// TESTING
// - Reset: hold reset 3 clks with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0 throughout.
// - MODE=0, CH=4, W=8: select=2, in_valid=4'b0100, data2=8'hA5, out_ready=1 -> next clk out_data=A5, out_ch=2.
// - MODE=0 backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_data stable 5 clks; out_ready=1 -> next word loads same clk.
// - MODE=0 select=5 with CH=5 (SELW=3) -> in_ready all 0, no transfer.
// - MODE=1, CH=4, all in_valid=1, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive clks; with in_valid=4'b1010 -> 1,3,1,3.
// - MODE=1 CH=3 wrap: ptr at 2, only ch0 valid -> grant 0, ptr becomes 1; with PARITY_EN, data 8'h07 -> out_parity=1.

Source files
------------

// File: rtl/mux_nx1_stream_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
// Latency: none (package only).
// Backpressure: none (package only).
package mux_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    // Width of a channel index; a one-channel index still needs one bit.
    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1_stream_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry it; valids never depend on readys.
interface mux_nx1_stream_if #(
    parameter int CH = 4,
    parameter int W  = 8
);
    localparam int SELW = mux_pkg::sel_width(CH);

    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [SELW-1:0] select;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_ch;

    // Environment side: drives producer words, select and consumer ready.
    modport master (
        output in_data, in_valid, select, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, select, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; caller gates the grant with its own load enable.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CH = 4
) (
    input  logic [CH-1:0]           req,
    input  logic [sel_width(CH)-1:0] ptr,
    output logic [CH-1:0]           grant,
    output logic [sel_width(CH)-1:0] idx,
    output logic                    any
);
    localparam int SELW = sel_width(CH);

    int  k;
    logic found;

    // Scan ptr, ptr+1, ... CH-1, 0, ... ptr-1 and take the first request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < CH; i++) begin
            k = int'(ptr) + i;
            if (k >= CH) k = k - CH;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = SELW'(k);
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream mux, external select (MODE=0) or round-robin (MODE=1).
// Latency: 1 clk from accepted input word to out_valid; full rate with out_ready high.
// Backpressure: in_ready only to the granted channel, only when the output register is free or draining.
// Optional MUX_NX1_STREAM_PARITY_EN adds out_parity = XOR of out_data, registered alongside it.
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int CH   = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_SELECT
) (
    input  logic                clk,
    input  logic                reset,
    mux_nx1_stream_if.slave     bus
`ifdef MUX_NX1_STREAM_PARITY_EN
    ,
    output logic                out_parity
`endif
);
    localparam int SELW = sel_width(CH);

    logic [SELW-1:0] g;
    logic [CH-1:0]   g_onehot;
    logic            grant_ok;
    logic            load_en;
    logic            xfer;
    logic [CH-1:0]   in_ready_c;
    logic [W-1:0]    word_g;
    logic [W-1:0]    data_q;
    logic [SELW-1:0] ch_q;
    logic            valid_q;

    assign load_en = !valid_q || bus.out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SELW-1:0] ptr;

        rr_arbiter #(.CH(CH)) u_arb (
            .req   (bus.in_valid),
            .ptr   (ptr),
            .grant (g_onehot),
            .idx   (g),
            .any   (grant_ok)
        );

        // Pointer moves just past the channel that was served.
        always_ff @(posedge clk) begin
            if (reset) begin
                ptr <= '0;
            end else if (xfer) begin
                ptr <= (int'(g) == CH - 1) ? '0 : g + SELW'(1);
            end
        end
    end else begin : g_sel
        assign g        = bus.select;
        assign grant_ok = (int'(bus.select) < CH);

        // Decode select; an out-of-range select matches no channel.
        always_comb begin
            g_onehot = '0;
            for (int k = 0; k < CH; k++) begin
                if (SELW'(k) == bus.select) g_onehot[k] = 1'b1;
            end
        end
    end

    // Ready only to the granted channel, never during reset.
    always_comb begin
        in_ready_c = '0;
        if (!reset && load_en && grant_ok) in_ready_c = g_onehot;
    end

    assign xfer         = |(bus.in_valid & in_ready_c);
    assign bus.in_ready = in_ready_c;

    // Pick the granted channel's word.
    always_comb begin
        word_g = '0;
        for (int k = 0; k < CH; k++) begin
            if (SELW'(k) == g) word_g = bus.in_data[k*W +: W];
        end
    end

    // Output register: load on transfer, empty when free with nothing offered, hold when stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else if (load_en) begin
            valid_q <= xfer;
            if (xfer) begin
                data_q <= word_g;
                ch_q   <= g;
            end
        end
    end

`ifdef MUX_NX1_STREAM_PARITY_EN
    // Parity travels with the data word it covers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (load_en && xfer) begin
            out_parity <= ^word_g;
        end
    end
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench over four instances: select CH=4, select CH=5, round-robin CH=4, round-robin CH=3.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// Optional MUX_NX1_STREAM_PARITY_EN adds the out_parity checks.
module tb_mux_nx1_stream;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mux_nx1_stream_if #(.CH(4), .W(8)) i0 ();
    mux_nx1_stream_if #(.CH(5), .W(8)) i1 ();
    mux_nx1_stream_if #(.CH(4), .W(8)) i2 ();
    mux_nx1_stream_if #(.CH(3), .W(8)) i3 ();

`ifdef MUX_NX1_STREAM_PARITY_EN
    logic par0, par1, par2, par3;
    mux_nx1_stream #(.CH(4), .W(8), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(i0), .out_parity(par0));
    mux_nx1_stream #(.CH(5), .W(8), .MODE(0)) u1 (.clk(clk), .reset(reset), .bus(i1), .out_parity(par1));
    mux_nx1_stream #(.CH(4), .W(8), .MODE(1)) u2 (.clk(clk), .reset(reset), .bus(i2), .out_parity(par2));
    mux_nx1_stream #(.CH(3), .W(8), .MODE(1)) u3 (.clk(clk), .reset(reset), .bus(i3), .out_parity(par3));
`else
    mux_nx1_stream #(.CH(4), .W(8), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(i0));
    mux_nx1_stream #(.CH(5), .W(8), .MODE(0)) u1 (.clk(clk), .reset(reset), .bus(i1));
    mux_nx1_stream #(.CH(4), .W(8), .MODE(1)) u2 (.clk(clk), .reset(reset), .bus(i2));
    mux_nx1_stream #(.CH(3), .W(8), .MODE(1)) u3 (.clk(clk), .reset(reset), .bus(i3));
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rr_exp_a [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [1:0] rr_exp_b [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    initial begin
        reset = 1'b1;
        i0.in_data = '0; i0.in_valid = '1; i0.select = '0; i0.out_ready = 1'b1;
        i1.in_data = '0; i1.in_valid = '1; i1.select = '0; i1.out_ready = 1'b1;
        i2.in_data = '0; i2.in_valid = '1; i2.select = '0; i2.out_ready = 1'b1;
        i3.in_data = '0; i3.in_valid = '1; i3.select = '0; i3.out_ready = 1'b1;

        // Reset held 3 clocks with every valid high.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_in_ready_sel", 32'(i0.in_ready), 32'h0);
            check_eq("rst_out_valid_sel", 32'(i0.out_valid), 32'h0);
            check_eq("rst_out_data_sel", 32'(i0.out_data), 32'h0);
            check_eq("rst_in_ready_rr", 32'(i2.in_ready), 32'h0);
            check_eq("rst_out_valid_rr", 32'(i2.out_valid), 32'h0);
        end
        check_eq("rst_out_ch", 32'(i2.out_ch), 32'h0);
        reset = 1'b0;
        i0.in_valid = '0; i1.in_valid = '0; i2.in_valid = '0; i3.in_valid = '0;
        tick();

        // Select mode: channel 2 word A5.
        i0.select = 2'd2; i0.in_valid = 4'b0100; i0.in_data = 32'h00A5_0000;
        #1;
        check_eq("sel_in_ready", 32'(i0.in_ready), 32'h4);
        tick();
        check_eq("sel_out_valid", 32'(i0.out_valid), 32'h1);
        check_eq("sel_out_data", 32'(i0.out_data), 32'hA5);
        check_eq("sel_out_ch", 32'(i0.out_ch), 32'h2);
`ifdef MUX_NX1_STREAM_PARITY_EN
        check_eq("sel_parity_a5", 32'(par0), 32'h0);
`endif

        // Backpressure: stalled output holds, no ready.
        i0.in_data = 32'h003C_0000; i0.out_ready = 1'b0;
        #1;
        check_eq("bp_in_ready", 32'(i0.in_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_hold_data", 32'(i0.out_data), 32'hA5);
            check_eq("bp_hold_valid", 32'(i0.out_valid), 32'h1);
            check_eq("bp_hold_ready", 32'(i0.in_ready), 32'h0);
        end
        i0.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(i0.in_ready), 32'h4);
        tick();
        check_eq("bp_next_data", 32'(i0.out_data), 32'h3C);

        // Select channel 1 while every channel is valid.
        i0.select = 2'd1; i0.in_valid = 4'b1111; i0.in_data = 32'h4433_5A11;
        #1;
        check_eq("sel1_in_ready", 32'(i0.in_ready), 32'h2);
        tick();
        check_eq("sel1_out_data", 32'(i0.out_data), 32'h5A);
        check_eq("sel1_out_ch", 32'(i0.out_ch), 32'h1);
        i0.in_valid = '0;
        tick();
        check_eq("sel_drain_valid", 32'(i0.out_valid), 32'h0);

        // CH=5: channel 4 loads, then out-of-range select 5 grants nothing.
        i1.select = 3'd4; i1.in_valid = 5'b11111; i1.in_data = 40'h99_0000_0000;
        tick();
        check_eq("ch5_out_data", 32'(i1.out_data), 32'h99);
        check_eq("ch5_out_ch", 32'(i1.out_ch), 32'h4);
        i1.select = 3'd5;
        #1;
        check_eq("ch5_sel5_in_ready", 32'(i1.in_ready), 32'h0);
        tick();
        check_eq("ch5_sel5_drained", 32'(i1.out_valid), 32'h0);
        i1.in_valid = '0;

        // Round-robin CH=4: all valid.
        i2.in_valid = 4'b1111; i2.in_data = 32'h1312_1110;
        #1;
        check_eq("rr_first_ready", 32'(i2.in_ready), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("rr_all_ch", 32'(i2.out_ch), 32'(c % 4));
            check_eq("rr_all_data", 32'(i2.out_data), 32'(rr_exp_a[c]));
        end
        i2.in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("rr_1010_ch", 32'(i2.out_ch), 32'(rr_exp_b[c]));
        end
        i2.in_valid = '0;
        tick();
        check_eq("rr_drain_valid", 32'(i2.out_valid), 32'h0);

        // Round-robin CH=3 wrap: move ptr to 2, then only ch0 valid.
        i3.in_data = 24'h33_22_07; i3.in_valid = 3'b010;
        tick();
        check_eq("rr3_first_ch", 32'(i3.out_ch), 32'h1);
        i3.in_valid = 3'b001;
        #1;
        check_eq("rr3_wrap_ready", 32'(i3.in_ready), 32'h1);
        tick();
        check_eq("rr3_wrap_ch", 32'(i3.out_ch), 32'h0);
        check_eq("rr3_wrap_data", 32'(i3.out_data), 32'h07);
`ifdef MUX_NX1_STREAM_PARITY_EN
        check_eq("rr3_parity_07", 32'(par3), 32'h1);
`endif
        i3.in_valid = 3'b111;
        #1;
        check_eq("rr3_ptr_after_wrap", 32'(i3.in_ready), 32'h2);
        tick();
        check_eq("rr3_next_ch", 32'(i3.out_ch), 32'h1);
        i3.in_valid = '0;

        // Reset mid-stream discards the pending word.
        i0.select = 2'd3; i0.in_valid = 4'b1000; i0.out_ready = 1'b0;
        tick();
        check_eq("mid_loaded", 32'(i0.out_data), 32'h44);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_valid", 32'(i0.out_valid), 32'h0);
        check_eq("mid_rst_data", 32'(i0.out_data), 32'h0);
        reset = 1'b0;
        i0.in_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
